pattern_buffer: RTL and testbench

PATTERN_BUFFER -- requirements
Module: pattern_buffer

---
 rtl/pat_pkg.sv | 26 ++
 rtl/pattern_ram.sv | 55 +++++
 rtl/pattern_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_pattern_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pat_pkg.sv
// ---------------------------------------------------------------------------
// pat_pkg
// Shared definitions for the pattern buffer: default widths for the slot
// index, field index and field data, plus the per-slot lifecycle states.
// No ports (package).
// ---------------------------------------------------------------------------
package pat_pkg;

    localparam int DEF_BUFP_WIDTH   = 3;   // 8 slots
    localparam int DEF_FIELDP_WIDTH = 5;   // 32 fields per slot
    localparam int DEF_BUFFER_WIDTH = 8;   // field data width

    // A slot walks FREE -> FILL -> FULL -> DONE -> FREE in ring order.
    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_FILL = 2'd1,
        SLOT_FULL = 2'd2,
        SLOT_DONE = 2'd3
    } slot_state_t;

    // Ingress may only write into a slot that is empty or partly filled.
    function automatic logic slot_accepts_fill(input slot_state_t s);
        return (s == SLOT_FREE) || (s == SLOT_FILL);
    endfunction

endpackage

// File: rtl/pattern_ram.sv
// ---------------------------------------------------------------------------
// pattern_ram
// Field storage: DEPTH x DATA_WIDTH array with one registered read port and
// two write ports. When both write ports hit the same address in one cycle
// the processor port wins. A read of an address being written in the same
// cycle returns the old contents.
// Ports:
//   clk, reset              clock, synchronous active-high reset (read reg only)
//   rd_addr / rd_data       registered read port (1-cycle latency)
//   ing_we/addr/wdata       ingress write port (lower priority)
//   proc_we/addr/wdata      processor write port (higher priority)
// ---------------------------------------------------------------------------
module pattern_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  ing_we,
    input  logic [ADDR_WIDTH-1:0] ing_addr,
    input  logic [DATA_WIDTH-1:0] ing_wdata,
    input  logic                  proc_we,
    input  logic [ADDR_WIDTH-1:0] proc_addr,
    input  logic [DATA_WIDTH-1:0] proc_wdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage is never cleared; the processor write is issued last so it
    // takes effect when both ports target the same word.
    always_ff @(posedge clk) begin
        if (ing_we) begin
            mem[ing_addr] <= ing_wdata;
        end
        if (proc_we) begin
            mem[proc_addr] <= proc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pattern_buffer.sv
// ---------------------------------------------------------------------------
// pattern_buffer
// Ring of slots holding variable-length patterns. Ingress fills the slot at
// the fill pointer, a processor reads/modifies the oldest FULL slot and marks
// it done, and egress streams DONE slots out before freeing them.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready  ingress stream
//   bufp, fieldp                       processor read select (1-cycle latency)
//   fieldwp, field_wdata, field_we     processor write (slot bufp)
//   field_rdata                        processor read data
//   proc_done                          processor finished oldest FULL slot
//   pat_avail, pat_bufp                oldest FULL slot indication
//   out_valid/out_data/out_last/out_ready  egress stream
// ---------------------------------------------------------------------------
module pattern_buffer
    import pat_pkg::*;
#(
    parameter int BUFP_WIDTH   = DEF_BUFP_WIDTH,
    parameter int FIELDP_WIDTH = DEF_FIELDP_WIDTH,
    parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [BUFFER_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic [BUFP_WIDTH-1:0]   bufp,
    input  logic [FIELDP_WIDTH-1:0] fieldp,
    input  logic [FIELDP_WIDTH-1:0] fieldwp,
    input  logic [BUFFER_WIDTH-1:0] field_wdata,
    input  logic                    field_we,
    output logic [BUFFER_WIDTH-1:0] field_rdata,
    input  logic                    proc_done,
    output logic                    pat_avail,
    output logic [BUFP_WIDTH-1:0]   pat_bufp,
    output logic                    out_valid,
    output logic [BUFFER_WIDTH-1:0] out_data,
    output logic                    out_last,
    input  logic                    out_ready
);

    localparam int NUM_SLOTS  = 1 << BUFP_WIDTH;
    localparam int LEN_WIDTH  = FIELDP_WIDTH + 1;
    localparam int ADDR_WIDTH = BUFP_WIDTH + FIELDP_WIDTH;
    localparam logic [FIELDP_WIDTH-1:0] FIELD_MAX = '1;

    // Per-slot state and length
    slot_state_t          state_q [NUM_SLOTS];
    slot_state_t          state_d [NUM_SLOTS];
    logic [LEN_WIDTH-1:0] len_q   [NUM_SLOTS];
    logic [LEN_WIDTH-1:0] len_d   [NUM_SLOTS];

    // Ring pointers and field cursors
    logic [BUFP_WIDTH-1:0]   fill_ptr_q, fill_ptr_d;
    logic [BUFP_WIDTH-1:0]   proc_ptr_q, proc_ptr_d;
    logic [BUFP_WIDTH-1:0]   drain_ptr_q, drain_ptr_d;
    logic [FIELDP_WIDTH-1:0] fill_idx_q, fill_idx_d;
    // Index of the next field to move into the egress output register.
    logic [LEN_WIDTH-1:0]    drain_idx_q, drain_idx_d;
    // The egress RAM copy currently presents field drain_idx_q of the drain slot.
    logic                    ram_ok_q, ram_ok_d;

    // Egress output register
    logic                    out_valid_q, out_valid_d;
    logic [BUFFER_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic                    in_fire;
    logic                    drain_active;
    logic                    out_pop;
    logic                    out_load;
    logic [FIELDP_WIDTH-1:0] drain_rd_idx;

    logic [ADDR_WIDTH-1:0]   ram_rd_addr [2];
    logic [BUFFER_WIDTH-1:0] ram_rd_data [2];

    assign in_ready    = slot_accepts_fill(state_q[fill_ptr_q]);
    assign in_fire     = in_valid && in_ready;
    assign pat_avail   = (state_q[proc_ptr_q] == SLOT_FULL);
    assign pat_bufp    = proc_ptr_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign field_rdata = ram_rd_data[0];

    // -----------------------------------------------------------------------
    // Next-state logic. Fill, process and drain each act only on a slot in
    // their own state, so they never touch the same slot in one cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        fill_ptr_d   = fill_ptr_q;
        proc_ptr_d   = proc_ptr_q;
        drain_ptr_d  = drain_ptr_q;
        fill_idx_d   = fill_idx_q;
        drain_idx_d  = drain_idx_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        ram_ok_d     = 1'b0;
        drain_active = 1'b0;
        out_pop      = 1'b0;
        out_load     = 1'b0;
        drain_rd_idx = drain_idx_q[FIELDP_WIDTH-1:0];

        // Ingress: a full-length pattern closes the slot even without in_last.
        if (in_fire) begin
            if (in_last || (fill_idx_q == FIELD_MAX)) begin
                state_d[fill_ptr_q] = SLOT_FULL;
                len_d[fill_ptr_q]   = {1'b0, fill_idx_q} + LEN_WIDTH'(1);
                fill_ptr_d          = fill_ptr_q + BUFP_WIDTH'(1);
                fill_idx_d          = '0;
            end else begin
                state_d[fill_ptr_q] = SLOT_FILL;
                fill_idx_d          = fill_idx_q + FIELDP_WIDTH'(1);
            end
        end

        // Processor completion; ignored unless a FULL slot is waiting.
        if (proc_done && pat_avail) begin
            state_d[proc_ptr_q] = SLOT_DONE;
            proc_ptr_d          = proc_ptr_q + BUFP_WIDTH'(1);
        end

        // Egress: the RAM copy is addressed one field ahead so the output
        // register can reload on every accepted beat.
        drain_active = (state_q[drain_ptr_q] == SLOT_DONE) &&
                       (drain_idx_q < len_q[drain_ptr_q]);
        out_pop      = out_valid_q && out_ready;
        out_load     = drain_active && ram_ok_q && (!out_valid_q || out_ready);

        if (out_pop) begin
            out_valid_d = 1'b0;
        end
        if (out_load) begin
            out_valid_d  = 1'b1;
            out_data_d   = ram_rd_data[1];
            out_last_d   = (drain_idx_q == len_q[drain_ptr_q] - LEN_WIDTH'(1));
            drain_idx_d  = drain_idx_q + LEN_WIDTH'(1);
            drain_rd_idx = drain_idx_q[FIELDP_WIDTH-1:0] + FIELDP_WIDTH'(1);
        end
        ram_ok_d = drain_active;

        // The final beat leaving frees the slot; out_load cannot coincide
        // because every field of this slot has already been loaded.
        if (out_pop && out_last_q) begin
            state_d[drain_ptr_q] = SLOT_FREE;
            drain_ptr_d          = drain_ptr_q + BUFP_WIDTH'(1);
            drain_idx_d          = '0;
            ram_ok_d             = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= SLOT_FREE;
                len_q[s]   <= '0;
            end
            fill_ptr_q  <= '0;
            proc_ptr_q  <= '0;
            drain_ptr_q <= '0;
            fill_idx_q  <= '0;
            drain_idx_q <= '0;
            ram_ok_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= state_d[s];
                len_q[s]   <= len_d[s];
            end
            fill_ptr_q  <= fill_ptr_d;
            proc_ptr_q  <= proc_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            fill_idx_q  <= fill_idx_d;
            drain_idx_q <= drain_idx_d;
            ram_ok_q    <= ram_ok_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // -----------------------------------------------------------------------
    // Field storage. Two identical copies receive the same writes so the
    // processor read port and the egress read port never compete.
    // -----------------------------------------------------------------------
    assign ram_rd_addr[0] = {bufp, fieldp};
    assign ram_rd_addr[1] = {drain_ptr_q, drain_rd_idx};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ram
        pattern_ram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (BUFFER_WIDTH)
        ) u_ram (
            .clk        (clk),
            .reset      (reset),
            .rd_addr    (ram_rd_addr[gi]),
            .rd_data    (ram_rd_data[gi]),
            .ing_we     (in_fire),
            .ing_addr   ({fill_ptr_q, fill_idx_q}),
            .ing_wdata  (in_data),
            .proc_we    (field_we),
            .proc_addr  ({bufp, fieldwp}),
            .proc_wdata (field_wdata)
        );
    end

endmodule

// File: tb/tb_pattern_buffer.sv
// ---------------------------------------------------------------------------
// tb_pattern_buffer
// Directed scenarios followed by randomized traffic. A behavioural model of
// the slot ring (plain arrays and integer pointers) predicts in_ready,
// pat_avail, pat_bufp, field_rdata and the egress stream; one compare process
// checks the DUT against it every cycle. Literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_pattern_buffer;

    localparam int NS = 8;
    localparam int NF = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic [4:0] fieldwp;
    logic [7:0] field_wdata;
    logic       field_we;
    logic [7:0] field_rdata;
    logic       proc_done;
    logic       pat_avail;
    logic [2:0] pat_bufp;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    always #5 clk = ~clk;

    pattern_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .bufp        (bufp),
        .fieldp      (fieldp),
        .fieldwp     (fieldwp),
        .field_wdata (field_wdata),
        .field_we    (field_we),
        .field_rdata (field_rdata),
        .proc_done   (proc_done),
        .pat_avail   (pat_avail),
        .pat_bufp    (pat_bufp),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // state: 0 FREE, 1 FILL, 2 FULL, 3 DONE
    int         m_state [NS];
    int         m_len   [NS];
    logic [7:0] m_mem   [NS][NF];
    bit         m_known [NS][NF];
    int         m_fill, m_proc, m_drain, m_fidx, m_didx;
    logic [7:0] m_rdata;
    bit         m_rdata_known;
    bit         hs = 1'b0;        // egress beat seen before this edge
    bit         chk_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] egress_log [$];

    initial begin
        for (int s = 0; s < NS; s++)
            for (int f = 0; f < NF; f++)
                m_known[s][f] = 1'b0;
    end

    always @(posedge clk) begin
        bit fill_ok;
        bit proc_ok;
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                m_state[s] = 0;
                m_len[s]   = 0;
            end
            m_fill = 0; m_proc = 0; m_drain = 0; m_fidx = 0; m_didx = 0;
            m_rdata = 8'h00;
            m_rdata_known = 1'b1;
        end else begin
            fill_ok = (m_state[m_fill] <= 1);
            proc_ok = proc_done && (m_state[m_proc] == 2);
            m_rdata       = m_mem[bufp][fieldp];
            m_rdata_known = m_known[bufp][fieldp];
            if (hs && m_state[m_drain] == 3) begin
                m_didx++;
                if (m_didx >= m_len[m_drain]) begin
                    m_state[m_drain] = 0;
                    m_drain = (m_drain + 1) % NS;
                    m_didx = 0;
                end
            end
            if (proc_ok) begin
                m_state[m_proc] = 3;
                m_proc = (m_proc + 1) % NS;
            end
            if (in_valid && fill_ok) begin
                m_mem[m_fill][m_fidx]   = in_data;
                m_known[m_fill][m_fidx] = 1'b1;
                if (in_last || m_fidx == NF - 1) begin
                    m_state[m_fill] = 2;
                    m_len[m_fill]   = m_fidx + 1;
                    m_fill = (m_fill + 1) % NS;
                    m_fidx = 0;
                end else begin
                    m_state[m_fill] = 1;
                    m_fidx++;
                end
            end
            if (field_we) begin
                m_mem[bufp][fieldwp]   = field_wdata;
                m_known[bufp][fieldwp] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (m_state[m_fill] <= 1));
            chk("pat_avail", pat_avail, (m_state[m_proc] == 2));
            chk("pat_bufp", pat_bufp, m_proc);
            if (m_rdata_known) chk("field_rdata", field_rdata, m_rdata);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid === 1'b1) begin
                chk("egress_slot_done", m_state[m_drain], 3);
                if (m_state[m_drain] == 3 && m_didx < NF) begin
                    chk("out_data", out_data, m_mem[m_drain][m_didx]);
                    chk("out_last", out_last, (m_didx == m_len[m_drain] - 1));
                end
            end
        end
        hs         = (out_valid === 1'b1) && out_ready;
        prev_stall = (out_valid === 1'b1) && !out_ready && !reset;
        prev_data  = out_data;
        prev_last  = out_last;
        if (hs && !reset) egress_log.push_back({out_last, out_data});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic send_field(input logic [7:0] d, input logic l);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 0, 1);
        step();
    endtask

    task automatic pulse_done();
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (egress_log.size() < n && c < budget) begin
            step();
            c++;
        end
        chk("egress_count", egress_log.size(), n);
    endtask

    task automatic chk_log(input int i, input logic [7:0] d, input logic l);
        if (i < egress_log.size()) begin
            chk("egress_data", egress_log[i][7:0], d);
            chk("egress_last", egress_log[i][8], l);
        end else begin
            chk("egress_missing", 0, 1);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_data = 0; in_last = 0;
        bufp = 0; fieldp = 0; fieldwp = 0; field_wdata = 0; field_we = 0;
        proc_done = 0; out_ready = 0;
        step();
        step();
        chk_en = 1'b1;
        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_field_rdata", field_rdata, 0);
        chk("rst_pat_avail", pat_avail, 0);
        chk("rst_pat_bufp", pat_bufp, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // five-field pattern into slot 0
        for (int i = 0; i < 5; i++) send_field(8'h11 + 8'(i), (i == 4));
        in_valid = 0; in_last = 0;
        chk("p1_pat_avail", pat_avail, 1);
        chk("p1_pat_bufp", pat_bufp, 0);
        chk("p1_model_len", m_len[0], 5);

        // registered read and read-during-write
        bufp = 0; fieldp = 2;
        step();
        chk("rd_field2", field_rdata, 8'h13);
        field_we = 1; fieldwp = 2; field_wdata = 8'hAA;
        step();
        chk("rd_collide_old", field_rdata, 8'h13);
        field_we = 0;
        step();
        chk("rd_after_write", field_rdata, 8'hAA);

        // process and drain slot 0
        egress_log.delete();
        out_ready = 1;
        pulse_done();
        chk("p1_done_avail", pat_avail, 0);
        wait_log(5, 40);
        chk_log(0, 8'h11, 0);
        chk_log(1, 8'h12, 0);
        chk_log(2, 8'hAA, 0);
        chk_log(3, 8'h14, 0);
        chk_log(4, 8'h15, 1);
        step();
        step();
        chk("p1_model_slot0_free", m_state[0], 0);
        chk("p1_out_valid_idle", out_valid, 0);

        // fill all eight slots, then recycle slot 0
        do_reset();
        out_ready = 0;
        for (int p = 0; p < 8; p++) begin
            send_field(8'h20 + 8'(p), 0);
            send_field(8'h30 + 8'(p), 1);
        end
        in_valid = 0; in_last = 0;
        chk("ring_full_in_ready", in_ready, 0);
        chk("ring_full_pat_bufp", pat_bufp, 0);
        egress_log.delete();
        out_ready = 1;
        pulse_done();
        wait_log(2, 40);
        chk_log(0, 8'h20, 0);
        chk_log(1, 8'h30, 1);
        step();
        chk("ring_freed_in_ready", in_ready, 1);
        send_field(8'h5A, 0);
        send_field(8'h5B, 1);
        in_valid = 0; in_last = 0;
        bufp = 0; fieldp = 1;
        step();
        chk("wrap_fill_slot0", field_rdata, 8'h5B);
        chk("wrap_pat_bufp", pat_bufp, 1);

        // 40 fields without last: slot 0 closes at 32
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 40; i++) send_field(8'(i), 0);
        in_valid = 0;
        chk("long_pat_avail", pat_avail, 1);
        chk("long_pat_bufp", pat_bufp, 0);
        chk("long_model_len", m_len[0], 32);
        egress_log.delete();
        pulse_done();
        chk("long_done_bufp", pat_bufp, 1);
        pulse_done();    // nothing FULL: must be ignored
        chk("ignored_done_bufp", pat_bufp, 1);
        chk("ignored_done_avail", pat_avail, 0);
        out_ready = 1;
        wait_log(32, 100);
        for (int i = 0; i < 32; i++) chk_log(i, 8'(i), (i == 31));
        send_field(8'd40, 1);
        in_valid = 0; in_last = 0;
        chk("spill_pat_avail", pat_avail, 1);
        chk("spill_pat_bufp", pat_bufp, 1);
        bufp = 1; fieldp = 0;
        step();
        chk("spill_field0", field_rdata, 8'd32);
        chk("spill_model_len", m_len[1], 9);

        // reset in the middle of a drain with toggling out_ready
        egress_log.delete();
        pulse_done();
        for (int c = 0; c < 60 && egress_log.size() < 3; c++) begin
            out_ready = c[0];
            step();
        end
        chk("drain_progress", (egress_log.size() >= 3), 1);
        out_ready = 1;
        reset = 1;
        step();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pat_avail", pat_avail, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        reset = 0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 2) != 0);
            in_data     = 8'($urandom);
            in_last     = ($urandom_range(0, 5) == 0);
            proc_done   = ($urandom_range(0, 7) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            bufp        = 3'($urandom);
            fieldp      = 5'($urandom);
            fieldwp     = 5'($urandom);
            field_wdata = 8'($urandom);
            field_we    = 0;
            if (m_state[m_proc] == 2 && $urandom_range(0, 2) == 0) begin
                field_we = 1;
                bufp     = 3'(m_proc);
            end
            step();
        end
        in_valid = 0; proc_done = 0; field_we = 0; out_ready = 1;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
